// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: turns datapath load/store strobes into a handshaked bus
// transaction, stalls the pipeline until it completes, and flags misalignment or timeout.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [1:0]        r_off;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [TO_W-1:0]   r_cnt;

  logic              w_access;
  logic [1:0]        w_size;
  logic              w_mis;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_rdata_sh;
  logic              w_to_hit;
  logic              w_cap_rd;
  logic              w_to;
  logic              w_unused;

  assign w_access   = mem_read | mem_write;
  assign w_size     = funct3[1:0];
  assign w_unused   = funct3[2];
  assign w_mis      = ((w_size == 2'b01) && addr[0]) ||
                      (w_size[1] && (addr[1:0] != 2'b00));
  assign w_wdata_sh = wdata << {addr[1:0], 3'b000};
  assign w_rdata_sh = bus_rdata >> {r_off, 3'b000};
  // Counter holds the number of REQ/RESP cycles already spent before this one.
  assign w_to_hit   = (r_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_be = 4'b1111;
    case (w_size)
      2'b00:   w_be = 4'b0001 << addr[1:0];
      2'b01:   w_be = 4'b0011 << {addr[1], 1'b0};
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cap_rd   = 1'b0;
    w_to       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) w_state_nx = w_mis ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (bus_gnt && r_we) begin
          w_state_nx = S_DONE;
        end else if (bus_gnt && bus_rvalid) begin
          w_cap_rd   = 1'b1;
          w_state_nx = S_DONE;
        end else if (w_to_hit) begin
          w_to       = 1'b1;
          w_state_nx = S_DONE;
        end else if (bus_gnt) begin
          w_state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (bus_rvalid) begin
          w_cap_rd   = 1'b1;
          w_state_nx = S_DONE;
        end else if (w_to_hit) begin
          w_to       = 1'b1;
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_off   <= 2'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_we    <= mem_write;
            r_addr  <= {addr[31:2], 2'b00};
            r_wdata <= w_wdata_sh;
            r_be    <= w_be;
            r_off   <= addr[1:0];
            r_err   <= w_mis;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
          end
        end
        S_REQ, S_RESP: begin
          r_cnt <= r_cnt + TO_W'(1);
          if (w_cap_rd) r_rdata <= w_rdata_sh;
          if (w_to) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        S_DONE:  r_err <= 1'b0;
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) && w_access) ||
                     (r_state == S_REQ) || (r_state == S_RESP);
  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;
  assign rdata     = (r_state == S_DONE) ? r_rdata : 32'd0;
  assign err       = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level model of each access (outcome, phase length,
// bus fields) checked cycle by cycle, plus directed cases with literal expectations.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'($urandom);
      addr       = $urandom;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'($urandom);
      bus_rdata  = $urandom;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_req",   32'(bus_req), 32'd0);
      chk("idle_err",   32'(err), 32'd0);
    end
  endtask

  // g: REQ cycle index carrying gnt; r: cycles from gnt to rvalid (0 = same cycle).
  task automatic run_access(input bit is_rd, input bit is_wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int g, input int r, input logic [31:0] word,
                            output logic [31:0] got_rdata, output bit got_err,
                            output int stall_cycles, output int req_cycles,
                            output logic [3:0] got_be);
    logic [1:0]  size, off;
    bit          mis, we, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr, exp_rdata;
    int          done_j, n_phase;

    size = f3[1:0];
    off  = a[1:0];
    we   = is_wr;
    mis  = (size == 2'd1 && off[0]) || (size >= 2'd2 && off != 2'd0);
    if (size == 2'd0)      exp_be = 4'(1 << off);
    else if (size == 2'd1) exp_be = off[1] ? 4'b1100 : 4'b0011;
    else                   exp_be = 4'b1111;
    exp_wd   = wd << (8 * off);
    exp_addr = {a[31:2], 2'b00};
    if (mis) begin
      n_phase = 0; exp_err = 1'b1; exp_rdata = 32'd0;
    end else begin
      done_j = we ? g : g + r;
      if (done_j <= TIMEOUT - 1) begin
        n_phase   = done_j + 1;
        exp_err   = 1'b0;
        exp_rdata = we ? 32'd0 : (word >> (8 * off));
      end else begin
        n_phase = TIMEOUT; exp_err = 1'b1; exp_rdata = 32'd0;
      end
    end

    stall_cycles = 0;
    req_cycles   = 0;
    got_be       = 4'd0;

    @(negedge clk);
    mem_read   = is_rd;
    mem_write  = is_wr;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'($urandom);
    bus_rdata  = $urandom;
    #1;
    if (stall) stall_cycles++;
    chk("acc_idle_stall", 32'(stall), 32'd1);
    chk("acc_idle_req",   32'(bus_req), 32'd0);

    for (int j = 0; j < n_phase; j++) begin
      @(negedge clk);
      bus_gnt    = (j == g);
      bus_rvalid = (!we && j == g + r) || (j < g && ($urandom % 2 == 1));
      bus_rdata  = (j == g + r) ? word : $urandom;
      #1;
      if (stall) stall_cycles++;
      if (bus_req) begin
        req_cycles++;
        got_be = bus_be;
      end
      chk("acc_stall", 32'(stall), 32'd1);
      chk("acc_req",   32'(bus_req), 32'(j <= g));
      chk("acc_err_early", 32'(err), 32'd0);
      if (j <= g) begin
        chk("acc_we",    32'(bus_we), 32'(we));
        chk("acc_addr",  bus_addr, exp_addr);
        chk("acc_be",    32'(bus_be), 32'(exp_be));
        chk("acc_wdata", bus_wdata, exp_wd);
      end
    end

    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'($urandom);
    bus_rdata  = $urandom;
    #1;
    if (stall) stall_cycles++;
    got_rdata = rdata;
    got_err   = err;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req",   32'(bus_req), 32'd0);
    chk("done_err",   32'(err), 32'(exp_err));
    if (!we || exp_err) chk("done_rdata", rdata, exp_rdata);
  endtask

  logic [31:0] o_rd;
  bit          o_err;
  int          o_stall, o_req;
  logic [3:0]  o_be;

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(2);

    // SW 0x100
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h11223344, 0, 0, 32'd0,
               o_rd, o_err, o_stall, o_req, o_be);
    chk("sw_be", 32'(o_be), 32'h0000000f);
    chk("sw_stall_cycles", 32'(o_stall), 32'd2);
    chk("sw_err", 32'(o_err), 32'd0);
    idle_cycles(1);

    // LB 0x103, gnt and rvalid together
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'hAABBCCDD,
               o_rd, o_err, o_stall, o_req, o_be);
    chk("lb_rdata", o_rd, 32'h000000AA);
    chk("lb_be", 32'(o_be), 32'h00000008);

    // LH 0x102, gnt on 4th REQ cycle, rvalid two cycles later
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 3, 2, 32'h12345678,
               o_rd, o_err, o_stall, o_req, o_be);
    chk("lh_be", 32'(o_be), 32'h0000000c);
    chk("lh_rdata", o_rd, 32'h00001234);
    chk("lh_stall_cycles", 32'(o_stall), 32'd7);

    // LW misaligned: back-to-back with previous instruction
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 0, 32'hFFFFFFFF,
               o_rd, o_err, o_stall, o_req, o_be);
    chk("mis_req_cycles", 32'(o_req), 32'd0);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_rdata", o_rd, 32'd0);
    chk("mis_stall_cycles", 32'(o_stall), 32'd1);
    idle_cycles(1);

    // LW, gnt never arrives
    run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 1000, 0, 32'h55555555,
               o_rd, o_err, o_stall, o_req, o_be);
    chk("to_req_cycles", 32'(o_req), 32'd8);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_rdata", o_rd, 32'd0);
    idle_cycles(1);

    // Reset while in REQ
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rreq_req_before", 32'(bus_req), 32'd1);
    mem_read = 1'b0;
    reset = 1'b0;
    #1;
    chk("rreq_req_after", 32'(bus_req), 32'd0);
    chk("rreq_stall_after", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(1);

    // Reset while in RESP, late rvalid afterwards
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h304;
    @(negedge clk);
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b0; mem_read = 1'b0;
    #1;
    chk("rresp_stall_before", 32'(stall), 32'd1);
    chk("rresp_req_before", 32'(bus_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("rresp_stall_after", 32'(stall), 32'd0);
    chk("rresp_rdata_after", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
      #1;
      chk("late_rv_stall", 32'(stall), 32'd0);
      chk("late_rv_err",   32'(err), 32'd0);
      chk("late_rv_rdata", rdata, 32'd0);
    end
    bus_rvalid = 1'b0;

    // Randomized accesses
    for (int k = 0; k < 300; k++) begin
      bit          wr, rd;
      logic [2:0]  f3;
      wr = 1'($urandom);
      rd = !wr || ($urandom % 4 == 0);
      f3 = {1'($urandom), 2'($urandom_range(0, 2))};
      run_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 9),
                 $urandom_range(0, 4), $urandom, o_rd, o_err, o_stall, o_req, o_be);
      if ($urandom % 3 == 0) idle_cycles($urandom_range(1, 2));
    end

    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
